// File: rtl/consecutive_three_ones.sv
// ---------------------------------------------------------------------------
// consecutive_three_ones
//
// Purpose:
//   Serial run-length detector. Watches a single-bit stream sampled on every
//   rising clock edge and raises a registered flag once the most recent
//   RUN_LEN samples were all 1. Internally a saturating run counter acts as
//   the Moore state (for RUN_LEN = 3: S0, S1, S2 and S3/detect).
//
// Parameters:
//   RUN_LEN  - consecutive 1 samples needed to assert y (legal 1..15)
//
// Ports:
//   clk  in   clock, all state changes on the rising edge
//   rst  in   synchronous active-low reset, has priority over everything
//   a    in   serial data, one sample per rising edge
//   y    out  detection flag, driven straight from a state register
//
// Configuration macro:
//   CONSEC_ONES_NONOVERLAP_EN - when defined, detection is non-overlapping:
//   from the detect state a further 1 restarts the count at 1, so y is a
//   single-cycle pulse per RUN_LEN-long group of ones. When undefined
//   (default), the counter saturates and y stays high for the whole run.
// ---------------------------------------------------------------------------
module consecutive_three_ones #(
    parameter int unsigned RUN_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic y
);

    localparam int unsigned CW = $clog2(RUN_LEN + 1);

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RUN_LEN);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          y_q;
    logic          y_d;

    // Next-state of the run counter. Encodings above RUN_LEN can only come
    // from an upset, and they drop straight back to zero so the detector
    // cannot stick in a state that never reports.
    always_comb begin
        cnt_d = CNT_ZERO;
        if (cnt_q > CNT_MAX) begin
            cnt_d = CNT_ZERO;
        end else if (!a) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
`ifdef CONSEC_ONES_NONOVERLAP_EN
            // The detected group is consumed; this 1 starts a fresh group.
            cnt_d = CNT_ONE;
`else
            cnt_d = CNT_MAX;
`endif
        end
    end

    // The flag is computed from the next state and registered alongside the
    // counter, so y is high exactly while cnt_q sits at RUN_LEN and has no
    // combinational dependence on a.
    always_comb begin
        y_d = (cnt_d == CNT_MAX);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= CNT_ZERO;
            y_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_consecutive_three_ones.sv
// ---------------------------------------------------------------------------
// tb_consecutive_three_ones
//
// Self-checking bench for consecutive_three_ones. The reference model just
// tracks how many 1s have arrived in a row since the last 0 or reset and
// derives the expected flag from that run length with plain arithmetic.
// Honours CONSEC_ONES_NONOVERLAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_consecutive_three_ones;

    localparam int unsigned RUN_LEN = 3;

    logic clk;
    logic rst;
    logic a;
    logic y;

    int vectors;
    int miscompares;
    int runLength;

    consecutive_three_ones #(
        .RUN_LEN(RUN_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .y  (y)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected flag from the current run length of consecutive ones.
    function automatic logic expectedY(input int run);
`ifdef CONSEC_ONES_NONOVERLAP_EN
        return (run > 0) && ((run % RUN_LEN) == 0);
`else
        return run >= RUN_LEN;
`endif
    endfunction

    // Compare the DUT flag against the model for one sampled cycle.
    task automatic checkOutput(input string tag);
        logic exp;
        exp = expectedY(runLength);
        vectors++;
        assert (y === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: y=%b expected %b (run=%0d)", tag, y, exp, runLength);
        end
    endtask

    // Drive one sample, let one rising edge consume it, update the model and
    // check the flag one time unit after the edge.
    task automatic applyStimulus(input logic aVal, input logic rstVal, input string tag);
        a   = aVal;
        rst = rstVal;
        @(posedge clk);
        #1;
        if (!rstVal)      runLength = 0;
        else if (aVal)    runLength = runLength + 1;
        else              runLength = 0;
        checkOutput(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        runLength   = 0;
        a   = 1'b0;
        rst = 1'b0;
        #2;

        // Reset held for two edges with a=1, then a run of three ones.
        applyStimulus(1'b1, 1'b0, "reset_hold0");
        applyStimulus(1'b1, 1'b0, "reset_hold1");
        applyStimulus(1'b1, 1'b1, "post_reset_1");
        applyStimulus(1'b1, 1'b1, "post_reset_2");
        applyStimulus(1'b1, 1'b1, "post_reset_3");
        applyStimulus(1'b0, 1'b1, "post_reset_clear");

        // Short run: 1,0,0 never asserts; then a full run proves cnt was 0.
        applyStimulus(1'b1, 1'b1, "short_1");
        applyStimulus(1'b0, 1'b1, "short_0a");
        applyStimulus(1'b0, 1'b1, "short_0b");
        applyStimulus(1'b1, 1'b1, "short_after_1");
        applyStimulus(1'b1, 1'b1, "short_after_2");
        applyStimulus(1'b1, 1'b1, "short_after_3");
        applyStimulus(1'b0, 1'b1, "short_after_0");

        // Long run 1,1,1,1,0.
        applyStimulus(1'b1, 1'b1, "long_1");
        applyStimulus(1'b1, 1'b1, "long_2");
        applyStimulus(1'b1, 1'b1, "long_3");
        applyStimulus(1'b1, 1'b1, "long_4");
        applyStimulus(1'b0, 1'b1, "long_0");

        // Exact run 0,0,1,1,1,0.
        applyStimulus(1'b0, 1'b1, "exact_0a");
        applyStimulus(1'b0, 1'b1, "exact_0b");
        applyStimulus(1'b1, 1'b1, "exact_1");
        applyStimulus(1'b1, 1'b1, "exact_2");
        applyStimulus(1'b1, 1'b1, "exact_3");
        applyStimulus(1'b0, 1'b1, "exact_0c");

        // Mid-run reset discards the partial count.
        applyStimulus(1'b1, 1'b1, "midrst_1");
        applyStimulus(1'b1, 1'b1, "midrst_2");
        applyStimulus(1'b1, 1'b0, "midrst_rst");
        applyStimulus(1'b1, 1'b1, "midrst_post1");
        applyStimulus(1'b1, 1'b1, "midrst_post2");
        applyStimulus(1'b1, 1'b1, "midrst_post3");
        applyStimulus(1'b0, 1'b1, "midrst_clear");

        // Seven ones: overlap keeps y high, non-overlap pulses on 3rd and 6th.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, "seven_ones");
        end
        applyStimulus(1'b0, 1'b1, "seven_clear");

        // Reset while detecting forces y low.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, "det_then_rst");
        end
        applyStimulus(1'b1, 1'b0, "rst_while_det");

        // Randomised stream biased toward ones, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic ra;
            logic rr;
            ra = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 24) != 0);
            applyStimulus(ra, rr, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/consecutive_three_ones.md
# consecutive_three_ones

Serial run-length detector: watches a single-bit input stream sampled on every rising clock edge and asserts a flag when the last `RUN_LEN` samples (default 3) were all 1. It is a small Moore state machine intended as a leaf block feeding control or event-counting logic. The output is registered and glitch-free.

## Interface
- `RUN_LEN`, default 3: number of consecutive 1 samples required to assert `y`. Legal range is 1 to 15.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `a` input, 1 bit: serial data, sampled once per rising edge.
- `y` output, 1 bit: detection flag, driven directly from state registers (Moore).

## Operation
- **State encoding.** State is a saturating run counter `cnt` of width ceil(log2(RUN_LEN+1)) bits, with values 0 to RUN_LEN.
  - For `RUN_LEN` = 3 the states are S0 (no 1 seen), S1, S2 and S3 (detect).
- **Transitions on each rising edge with `rst`=1:**
  - `a`=0: `cnt` goes to 0 from any state.
  - `a`=1 and `cnt` < RUN_LEN: `cnt` goes to `cnt`+1.
  - `a`=1 and `cnt` = RUN_LEN: `cnt` stays at RUN_LEN (overlapping detection, default build).
- **Output.** `y` = 1 exactly when `cnt` = RUN_LEN, otherwise 0.
- **Reset.** `rst`=0 on a rising edge forces `cnt` to 0 and `y` to 0, regardless of `a`.
  - Reset has priority over all transitions.
  - Reset mid-run discards the partial count.
- **Before reset.** Until the first rising edge with `rst`=0, `cnt` and `y` are undefined. No power-on initial value is required.
- **Illegal state recovery.** Any encoding of `cnt` above RUN_LEN returns to 0 on the next edge.
- **Run lengths.** A run of N ones, with N ≥ RUN_LEN, asserts `y` for N−RUN_LEN+1 consecutive cycles in the default build.

## Timing
- **Latency.** `y` rises on the same rising edge that samples the RUN_LEN-th consecutive 1, and is visible in the following cycle.
- **Deassertion.** `y` falls on the edge that samples a 0 or samples `rst`=0.
- **No combinational path.** There is no combinational path from `a` to `y`.
- **Throughput.** One sample per clock. There are no handshake or enable signals.

## Configuration
- **`CONSEC_ONES_NONOVERLAP_EN` undefined (default):** overlapping detection as described above. Input `1111` gives `y` high for 2 cycles.
- **`CONSEC_ONES_NONOVERLAP_EN` defined:** non-overlapping detection.
  - From `cnt` = RUN_LEN, `a`=1 moves to `cnt`=1 and `a`=0 moves to `cnt`=0.
  - `y` is therefore a single-cycle pulse per RUN_LEN-long group of ones.
  - Input `111111` gives 2 pulses, on the 3rd and 6th samples.
- All other behaviour is identical in both builds, including reset, latency and output encoding.

## Test plan
- **Reset.** Hold `rst`=0 for 2 edges with `a`=1.
  - Expect `y`=0 throughout.
  - Release `rst`; `y` stays 0 for the next 2 edges of `a`=1 and rises on the 3rd.
- **Short runs.** Drive `a` = 1,0,0.
  - Expect `y`=0 on every cycle.
  - After the 0 samples, `cnt` must be back at 0.
- **Long run, default build.** Drive `a` = 1,1,1,1,0.
  - Expect `y` = 0,0,1,1,0, each value seen after the corresponding edge.
- **Exact run.** Drive `a` = 0,0,1,1,1,0.
  - Expect `y` high for exactly one cycle, following the 3rd 1.
- **Mid-run reset.** Drive `a` = 1,1; then apply `rst`=0 for one edge with `a`=1; then release and drive `a` = 1,1.
  - Expect `y`=0 until the 3rd post-reset 1.
- **Non-overlap build.** With `CONSEC_ONES_NONOVERLAP_EN` defined, drive `a` = 1,1,1,1,1,1,1.
  - Expect `y` high only after the 3rd and 6th samples, 0 elsewhere.
